// File: rtl/reg_sum_writer_pkg.sv
// -----------------------------------------------------------------------------
// reg_sum_writer_pkg
// Shared types and constants for the register-sum write-back sequencer:
// register-number and data widths, the default element-count width, the
// sequencer state encoding and a helper for wrapping source addresses.
// No ports (package).
// -----------------------------------------------------------------------------
package reg_sum_writer_pkg;

  // Register file geometry: 32 registers of 32 bits
  localparam int REG_NUM_W     = 5;
  localparam int DATA_W        = 32;

  // Element count must represent 0..32 inclusive
  localparam int CNT_WIDTH_DEF = 6;

  typedef logic [REG_NUM_W-1:0] reg_num_t;
  typedef logic [DATA_W-1:0]    data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Source register for element idx; the sum is done in register-number
  // width so that register 31 is followed by register 0
  function automatic reg_num_t srcAddr(reg_num_t base, reg_num_t idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/reg_sum_writer_if.sv
// -----------------------------------------------------------------------------
// reg_sum_writer_if
// Bundles the request inputs, the register-file read/write port and the
// status outputs of reg_sum_writer.
//   start, srcBase, count, dstNum : request (sampled by the sequencer in IDLE)
//   sum                           : adder output, regfile[rdNumA] + regfile[rdNumB]
//   rdNumA, rdNumB                : register-file read port numbers
//   wrData, wrNum, wrEnable       : register-file write port
//   busy, done                    : status
// Modports: master = the sequencer, slave = the environment
// (register file / adder / requester).
// -----------------------------------------------------------------------------
interface reg_sum_writer_if
  import reg_sum_writer_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) ();

  logic                 start;
  reg_num_t             srcBase;
  logic [CNT_WIDTH-1:0] count;
  reg_num_t             dstNum;
  data_t                sum;

  reg_num_t             rdNumA;
  reg_num_t             rdNumB;
  data_t                wrData;
  reg_num_t             wrNum;
  logic                 wrEnable;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, srcBase, count, dstNum, sum,
    output rdNumA, rdNumB, wrData, wrNum, wrEnable, busy, done
  );

  modport slave (
    output start, srcBase, count, dstNum, sum,
    input  rdNumA, rdNumB, wrData, wrNum, wrEnable, busy, done
  );

endinterface

// File: rtl/reg_sum_writer.sv
// -----------------------------------------------------------------------------
// reg_sum_writer
// Write-back sequencer in front of a 2-read/1-write register file and an
// adder. On an accepted start it clears the destination register, then for
// each of `count` consecutive source registers writes dst + src back into
// dst, one source per cycle, and finally pulses done.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : reg_sum_writer_if.master (request, register-file ports, status)
// -----------------------------------------------------------------------------
module reg_sum_writer
  import reg_sum_writer_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_sum_writer_if.master        bus_io
);

  state_e               state_q, state_d;
  reg_num_t             src_q, src_d;
  reg_num_t             dst_q, dst_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;

  logic                 cntIsZero;
  logic                 lastElem;

  assign cntIsZero = (cnt_q == '0);
  assign lastElem  = (idx_q == (cnt_q - CNT_WIDTH'(1)));

  // State and request registers; reset forces IDLE with all latched
  // request fields zero, which makes every output zero at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: the request is latched only when accepted in IDLE,
  // so start and request changes while busy have no effect
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          src_d   = bus_io.srcBase;
          dst_d   = bus_io.dstNum;
          cnt_d   = bus_io.count;
          idx_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = cntIsZero ? DONE : ACCUM;
      end
      ACCUM: begin
        idx_d = idx_q + CNT_WIDTH'(1);
        if (lastElem) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: everything except wrData in ACCUM depends on registered
  // state only; wrData in ACCUM passes the adder result straight through
  // so the write at the end of the cycle already contains dst + src
  always_comb begin
    bus_io.rdNumA   = dst_q;
    bus_io.rdNumB   = src_q;
    bus_io.wrNum    = dst_q;
    bus_io.wrData   = '0;
    bus_io.wrEnable = 1'b0;
    bus_io.busy     = (state_q != IDLE);
    bus_io.done     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        bus_io.wrEnable = 1'b1;
      end
      ACCUM: begin
        bus_io.rdNumB   = srcAddr(src_q, idx_q[REG_NUM_W-1:0]);
        bus_io.wrEnable = 1'b1;
        bus_io.wrData   = bus_io.sum;
      end
      DONE: begin
        bus_io.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_reg_sum_writer.sv
// -----------------------------------------------------------------------------
// tb_reg_sum_writer
// Environment for reg_sum_writer: a behavioural register file and adder,
// a request driver with a scoreboard queue, and a monitor that checks every
// write and every done pulse against the expected operation.
// No ports.
// -----------------------------------------------------------------------------
module tb_reg_sum_writer;
  import reg_sum_writer_pkg::*;

  localparam int CW = CNT_WIDTH_DEF;

  logic clk = 1'b0;
  logic rst;

  reg_sum_writer_if #(.CNT_WIDTH(CW)) busIf ();

  reg_sum_writer #(.CNT_WIDTH(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (busIf)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads, write on the rising edge; a bulk
  // load port lets the bench set every register while the sequencer is idle
  data_t rf      [32];
  data_t image   [32];
  data_t modelRf [32];
  logic  loadReq;

  always @(posedge clk) begin
    if (loadReq) begin
      for (int k = 0; k < 32; k++) rf[k] <= image[k];
    end else if (busIf.wrEnable) begin
      rf[busIf.wrNum] <= busIf.wrData;
    end
  end

  assign busIf.sum = rf[busIf.rdNumA] + rf[busIf.rdNumB];

  typedef struct {
    reg_num_t dst;
    reg_num_t src;
    int       cnt;
    data_t    value;
    int       startCyc;
  } exp_t;

  exp_t     sbQ[$];
  reg_num_t rdSeq[$];
  int       writeCnt = 0;
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  logic     monEnable = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: destination cleared, then each source added in order using
  // the register contents as they stand at that step (covers dst aliasing)
  task automatic modelOp(input reg_num_t src, input int cnt, input reg_num_t dst,
                         output data_t result);
    modelRf[dst] = '0;
    for (int i = 0; i < cnt; i++) begin
      modelRf[dst] = modelRf[dst] + modelRf[(int'(src) + i) % 32];
    end
    result = modelRf[dst];
  endtask

  task automatic loadImage();
    @(negedge clk);
    for (int k = 0; k < 32; k++) modelRf[k] = image[k];
    loadReq = 1'b1;
    @(posedge clk);
    #1 loadReq = 1'b0;
  endtask

  // Monitor: busy must match "an operation is in flight", every write must
  // target the expected destination, and each done pulse closes one entry
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
      rdSeq.delete();
      writeCnt = 0;
    end else if (monEnable) begin
      checkOutput("busy", {63'd0, busIf.busy}, {63'd0, sbQ.size() != 0});
      if (busIf.wrEnable) begin
        if (sbQ.size() == 0) begin
          checkOutput("spuriousWrite", {63'd0, busIf.wrEnable}, 64'd0);
        end else begin
          checkOutput("wrNum", 64'(busIf.wrNum), 64'(sbQ[0].dst));
          checkOutput("rdNumA", 64'(busIf.rdNumA), 64'(sbQ[0].dst));
          if (writeCnt == 0) checkOutput("clearData", 64'(busIf.wrData), 64'd0);
          rdSeq.push_back(busIf.rdNumB);
          writeCnt++;
        end
      end
      if (busIf.done) begin
        if (sbQ.size() == 0) begin
          checkOutput("spuriousDone", {63'd0, busIf.done}, 64'd0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("result", 64'(rf[e.dst]), 64'(e.value));
          checkOutput("latency", 64'(cyc - e.startCyc + 1), 64'(e.cnt + 2));
          checkOutput("writes", 64'(writeCnt), 64'(e.cnt + 1));
          for (int i = 0; i < e.cnt; i++) begin
            if (i + 1 < rdSeq.size())
              checkOutput("rdNumB", 64'(rdSeq[i+1]), 64'((int'(e.src) + i) % 32));
          end
          rdSeq.delete();
          writeCnt = 0;
        end
      end
    end
  end

  // Issue one request, hold start for extra cycles if asked, then scramble
  // the request inputs (they must not matter after acceptance) and wait
  // for the monitor to retire the operation
  task automatic applyStimulus(input reg_num_t src, input int cnt, input reg_num_t dst,
                               input int holdCycles);
    data_t expVal;
    exp_t  e;
    @(negedge clk);
    busIf.start   = 1'b1;
    busIf.srcBase = src;
    busIf.count   = CW'(cnt);
    busIf.dstNum  = dst;
    @(posedge clk);
    #1;
    modelOp(src, cnt, dst, expVal);
    e.dst = dst; e.src = src; e.cnt = cnt; e.value = expVal; e.startCyc = cyc;
    sbQ.push_back(e);
    repeat (holdCycles) @(posedge clk);
    #1;
    busIf.start   = 1'b0;
    busIf.srcBase = reg_num_t'($urandom);
    busIf.count   = CW'($urandom_range(32, 0));
    busIf.dstNum  = reg_num_t'($urandom);
    for (int t = 0; t < 200 && sbQ.size() != 0; t++) @(posedge clk);
    if (sbQ.size() != 0) begin
      checkOutput("doneTimeout", 64'(sbQ.size()), 64'd0);
    end
  endtask

  task automatic clearImage();
    for (int k = 0; k < 32; k++) image[k] = '0;
  endtask

  initial begin
    rst = 1'b1;
    loadReq = 1'b0;
    busIf.start = 1'b0;
    busIf.srcBase = '0;
    busIf.count = '0;
    busIf.dstNum = '0;
    #3;
    checkOutput("resetWrEnable", {63'd0, busIf.wrEnable}, 64'd0);
    checkOutput("resetBusy", {63'd0, busIf.busy}, 64'd0);
    checkOutput("resetDone", {63'd0, busIf.done}, 64'd0);
    checkOutput("resetRdNumA", 64'(busIf.rdNumA), 64'd0);
    checkOutput("resetRdNumB", 64'(busIf.rdNumB), 64'd0);
    checkOutput("resetWrNum", 64'(busIf.wrNum), 64'd0);
    checkOutput("resetWrData", 64'(busIf.wrData), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idleWrEnable", {63'd0, busIf.wrEnable}, 64'd0);
    end
    monEnable = 1'b1;

    // Basic three-element sum
    clearImage();
    image[1] = 32'd10; image[2] = 32'd20; image[3] = 32'd30;
    loadImage();
    applyStimulus(5'd1, 3, 5'd8, 0);
    checkOutput("sum60", 64'(rf[8]), 64'd60);

    // Zero-length request only clears the destination
    clearImage();
    image[4] = 32'd99;
    loadImage();
    applyStimulus(5'd2, 0, 5'd4, 0);
    checkOutput("clearOnly", 64'(rf[4]), 64'd0);

    // Source range wrapping past register 31
    clearImage();
    image[30] = 32'd1; image[31] = 32'd2; image[0] = 32'd3; image[1] = 32'd4;
    loadImage();
    applyStimulus(5'd30, 4, 5'd9, 0);
    checkOutput("wrapSum", 64'(rf[9]), 64'd10);

    // Modular overflow, then destination aliasing a source
    clearImage();
    image[5] = 32'hFFFF_FFFF; image[6] = 32'd2;
    loadImage();
    applyStimulus(5'd5, 2, 5'd7, 0);
    checkOutput("overflow", 64'(rf[7]), 64'h1);
    loadImage();
    applyStimulus(5'd5, 2, 5'd6, 0);
    checkOutput("alias", 64'(rf[6]), 64'hFFFF_FFFE);

    // start held into ACCUM must not restart the sequence
    for (int k = 0; k < 32; k++) image[k] = 32'(k * 3 + 1);
    loadImage();
    applyStimulus(5'd10, 4, 5'd20, 2);

    // Reset in the middle of ACCUM: outputs drop without waiting for a clock
    monEnable = 1'b0;
    @(negedge clk);
    busIf.start = 1'b1; busIf.srcBase = 5'd0; busIf.count = CW'(8); busIf.dstNum = 5'd3;
    @(posedge clk);
    #1 busIf.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstWrEnable", {63'd0, busIf.wrEnable}, 64'd0);
    checkOutput("midRstBusy", {63'd0, busIf.busy}, 64'd0);
    checkOutput("midRstDone", {63'd0, busIf.done}, 64'd0);
    checkOutput("midRstRdNumA", 64'(busIf.rdNumA), 64'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    monEnable = 1'b1;
    loadImage();
    applyStimulus(5'd0, 8, 5'd3, 0);

    // Randomized back-to-back requests, with occasional fresh register images
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        for (int k = 0; k < 32; k++) image[k] = $urandom;
        loadImage();
      end
      applyStimulus(reg_num_t'($urandom), $urandom_range(32, 0), reg_num_t'($urandom),
                    $urandom_range(1, 0));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_sum_writer.md
# reg_sum_writer

Multi-cycle write-back sequencer for the 2-read/1-write register file plus adder datapath. On a start request it clears a destination register, then drives the read ports and write port once per cycle so the adder's sum of the destination (running total) and each source register is written back into the destination. The result is the sum of a contiguous block of registers. It is the writer/controller that sits in front of the register-file/adder pair and owns its write port.

## Interface
Parameters:
- CNT_WIDTH, 6, width of the element count; must hold 0..32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- srcBase  in  `RegNumPath  first source register number.
- count  in  CNT_WIDTH  number of source registers to sum, 0..32.
- dstNum  in  `RegNumPath  destination/accumulator register number.
- sum  in  `DataPath  adder output, i.e. regfile[rdNumA] + regfile[rdNumB].
- rdNumA  out  `RegNumPath  read port A; always the latched destination.
- rdNumB  out  `RegNumPath  read port B; current source register.
- wrData  out  `DataPath  write data to the register file.
- wrNum  out  `RegNumPath  write register number.
- wrEnable  out  1  write strobe.
- busy  out  1  high from the cycle after start is accepted until DONE ends.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, ACCUM, DONE.
- IDLE: if start=1, latch srcBase, count and dstNum, and set index i=0. Go to CLEAR. Otherwise stay.
- CLEAR: wrEnable=1, wrNum=dst, wrData=0. Next state is ACCUM if count≠0, else DONE.
- ACCUM: rdNumA=dst, rdNumB=(srcBase+i) mod 32, wrEnable=1, wrNum=dst, wrData=sum.
  - Increment i each cycle.
  - Leave for DONE after the cycle where i=count-1.
- DONE: done=1, wrEnable=0. Then return to IDLE.
- Address arithmetic is in `RegNumPath width, so it wraps naturally (31 → 0).
- Sum arithmetic is `DataPath width, modulo 2^32. There is no overflow flag.
- If dst lies inside the source range, the source read returns the current running total. Result is defined as the plain sequential computation; no special case.
- start while busy is ignored. Inputs are latched only on acceptance.
- Outputs in IDLE/DONE: wrEnable=0, wrData=0, wrNum=latched dst, rdNumA=latched dst, rdNumB=latched srcBase.

## Timing
- Reset value: state=IDLE, and every output is 0 (rdNumA, rdNumB, wrData, wrNum, wrEnable, busy, done).
- rst is asynchronous: wrEnable, busy and done drop immediately on assertion, not at the next edge.
- Reset mid-operation abandons the sum. The destination holds whatever was written at the last completed edge.
- Register-file reads are combinational; writes occur on the clk edge that ends the cycle.
- One source is consumed per cycle. The write at the end of cycle k is visible to the read in cycle k+1.
- Latency, start edge to done pulse: count+2 cycles. That is CLEAR (1 cycle) + ACCUM (count cycles), with done asserted in the following cycle.
- wrData in ACCUM is combinational from sum. Every other output is a function of registered state only.
- A new start is accepted in the first IDLE cycle after DONE.

## Structure
- `RegNumPath and `DataPath come from Types.v.
- State encoding (2 bits) and CNT_WIDTH default go into Types.v as shared constants.
- Single module: FSM plus index counter. No sub-module.
- Integration top: reg_sum_writer instantiated with RegisterFile and Adder. Its read/write ports drive the register file; sum connects to the adder output.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately; after release, state IDLE and no write.
- r1=10, r2=20, r3=30; start with srcBase=1, count=3, dstNum=8 → r8=60; done pulses 5 cycles after the start edge; busy high for those cycles.
- count=0, dstNum=4, r4=99 → exactly one write, r4=0; done 2 cycles after start.
- Wrap: r30=1, r31=2, r0=3, r1=4; srcBase=30, count=4, dst=9 → rdNumB sequence 30, 31, 0, 1; r9=10.
- Overflow/aliasing: r5=0xFFFFFFFF, r6=2, srcBase=5, count=2, dst=7 → r7=0x00000001. Separately, dst=6 inside the source range → r6=0xFFFFFFFF then 0xFFFFFFFE (sequential rule).
- Control: start held during ACCUM → ignored, no restart. rst asserted during ACCUM → wrEnable drops at once; a subsequent start completes normally.
